// File: rtl/timer_bank_pkg.sv
// Shared definitions for the timer bank: state encoding and default sizing.
package timer_bank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int TB_DIV_DEF = 10;
    localparam int NCH_DEF    = 2;
    localparam int QW_DEF     = 8;

endpackage

// File: rtl/timer_bank_tb_gen.sv
// Timebase divider: counts enabled clocks and emits a one-clock tick every TB_DIV of them.
module timer_bank_tb_gen
    import timer_bank_pkg::*;
#(
    parameter int TB_DIV = TB_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    // A divide-by-one still needs a one-bit counter that sits at zero.
    localparam int             CW   = (TB_DIV > 1) ? $clog2(TB_DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(TB_DIV - 1);

    logic [CW-1:0] cnt_q;

    // Count enabled clocks; wrap at LAST and pulse tick; hold count while disabled.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else if (clr) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_q <= '0;
                tick  <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
                tick  <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/timer_bank.sv
// Timer bank: shared tick counter with per-channel terminal-count compares,
// one-shot or periodic, with pause and synchronous run clear.
module timer_bank
    import timer_bank_pkg::*;
#(
    parameter int TB_DIV = TB_DIV_DEF,
    parameter int NCH    = NCH_DEF,
    parameter int QW     = QW_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              RST_Q,
    input  logic              PAUSE,
    input  logic              MODE,
    input  logic [NCH*QW-1:0] LIMITS,
    output logic              TICK,
    output logic [QW-1:0]     Q,
    output logic [NCH-1:0]    TC,
    output logic              BUSY,
    output logic              DONE
);

    state_e            state_q, state_d;
    logic [NCH*QW-1:0] lim_q;
    logic              mode_q;
    logic              hold_q;      // tick that arrived while paused, consumed on release
    logic [QW-1:0]     q_inc;
    logic [QW-1:0]     lim_last;
    logic [NCH-1:0]    tc_hit;
    logic              start_ok;
    logic              run_go;
    logic              tick_evt;
    logic              at_term;
    logic              tb_en;
    logic              tb_clr;

    assign q_inc    = Q + 1'b1;
    assign lim_last = lim_q[(NCH-1)*QW +: QW];

    // One comparator per channel against the shared count; a zero limit never fires.
    for (genvar i = 0; i < NCH; i++) begin : g_cmp
        assign tc_hit[i] = (lim_q[i*QW +: QW] != '0) && (q_inc == lim_q[i*QW +: QW]);
    end

    timer_bank_tb_gen #(.TB_DIV(TB_DIV)) u_tb_gen (
        .clk   (CLK),
        .rst_n (RST),
        .en    (tb_en),
        .clr   (tb_clr),
        .tick  (TICK)
    );

    // Next-state and control decode in priority order: clear, start, terminal.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned
        // and no latch is inferred.
        start_ok = START && (LIMITS[(NCH-1)*QW +: QW] != '0);
        run_go   = (state_q == ST_RUN) && !PAUSE;
        tick_evt = TICK || hold_q;
        at_term  = run_go && tick_evt && (q_inc == lim_last);
        state_d  = state_q;
        tb_clr   = RST_Q || start_ok;
        // A one-shot terminal stops the timebase so no tick leaks into DONE.
        tb_en    = run_go && !(at_term && !mode_q);
        if (RST_Q) begin
            state_d = ST_IDLE;
        end else if (start_ok) begin
            state_d = ST_RUN;
        end else if (at_term && !mode_q) begin
            state_d = ST_DONE;
        end
    end

    // State, count, latched configuration and registered status outputs.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            Q       <= '0;
            TC      <= '0;
            lim_q   <= '0;
            mode_q  <= 1'b0;
            hold_q  <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            state_q <= state_d;
            BUSY    <= (state_d == ST_RUN);
            DONE    <= (state_d == ST_DONE);
            if (RST_Q) begin
                Q      <= '0;
                TC     <= '0;
                hold_q <= 1'b0;
            end else if (start_ok) begin
                Q      <= '0;
                TC     <= '0;
                hold_q <= 1'b0;
                lim_q  <= LIMITS;
                mode_q <= MODE;
            end else if ((state_q == ST_RUN) && PAUSE) begin
                TC     <= '0;
                hold_q <= tick_evt;
            end else if (run_go && tick_evt) begin
                hold_q <= 1'b0;
                TC     <= tc_hit;
                Q      <= (at_term && mode_q) ? '0 : q_inc;
            end else begin
                TC <= '0;
            end
        end
    end

endmodule

// File: tb/tb_timer_bank.sv
// Directed self-checking bench for timer_bank at three timebase divisors.
module tb_timer_bank;

    localparam int D10 = 0;
    localparam int D4  = 1;
    localparam int D1  = 2;

    logic        tb_CLK = 1'b0;
    logic        tb_RST;
    logic        start_s [3];
    logic        rstq_s  [3];
    logic        pause_s [3];
    logic        mode_s  [3];
    logic [15:0] lim_s   [3];
    logic        tick_s  [3];
    logic [7:0]  q_s     [3];
    logic [1:0]  tc_s    [3];
    logic        busy_s  [3];
    logic        done_s  [3];

    int checks = 0;
    int errors = 0;

    always #5 tb_CLK = ~tb_CLK;

    timer_bank #(.TB_DIV(10), .NCH(2), .QW(8)) u10 (
        .CLK(tb_CLK), .RST(tb_RST), .START(start_s[D10]), .RST_Q(rstq_s[D10]),
        .PAUSE(pause_s[D10]), .MODE(mode_s[D10]), .LIMITS(lim_s[D10]),
        .TICK(tick_s[D10]), .Q(q_s[D10]), .TC(tc_s[D10]), .BUSY(busy_s[D10]), .DONE(done_s[D10])
    );

    timer_bank #(.TB_DIV(4), .NCH(2), .QW(8)) u4 (
        .CLK(tb_CLK), .RST(tb_RST), .START(start_s[D4]), .RST_Q(rstq_s[D4]),
        .PAUSE(pause_s[D4]), .MODE(mode_s[D4]), .LIMITS(lim_s[D4]),
        .TICK(tick_s[D4]), .Q(q_s[D4]), .TC(tc_s[D4]), .BUSY(busy_s[D4]), .DONE(done_s[D4])
    );

    timer_bank #(.TB_DIV(1), .NCH(2), .QW(8)) u1 (
        .CLK(tb_CLK), .RST(tb_RST), .START(start_s[D1]), .RST_Q(rstq_s[D1]),
        .PAUSE(pause_s[D1]), .MODE(mode_s[D1]), .LIMITS(lim_s[D1]),
        .TICK(tick_s[D1]), .Q(q_s[D1]), .TC(tc_s[D1]), .BUSY(busy_s[D1]), .DONE(done_s[D1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, landing 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge tb_CLK);
            #1;
        end
    endtask

    task automatic check_all(input int d, input string tag, input logic tk, input logic [7:0] q,
                             input logic [1:0] tc, input logic bz, input logic dn);
        check($sformatf("%s.tick", tag), 32'(tick_s[d]), 32'(tk));
        check($sformatf("%s.q",    tag), 32'(q_s[d]),    32'(q));
        check($sformatf("%s.tc",   tag), 32'(tc_s[d]),   32'(tc));
        check($sformatf("%s.busy", tag), 32'(busy_s[d]), 32'(bz));
        check($sformatf("%s.done", tag), 32'(done_s[d]), 32'(dn));
    endtask

    task automatic do_start(input int d, input logic [15:0] lim, input logic md);
        lim_s[d]   = lim;
        mode_s[d]  = md;
        start_s[d] = 1'b1;
        step(1);
        start_s[d] = 1'b0;
    endtask

    initial begin
        logic [1:0] etc;
        int         c;
        tb_RST = 1'b0;
        for (int d = 0; d < 3; d++) begin
            start_s[d] = 1'b0;
            rstq_s[d]  = 1'b0;
            pause_s[d] = 1'b0;
            mode_s[d]  = 1'b0;
            lim_s[d]   = 16'h0000;
        end
        step(2);
        for (int d = 0; d < 3; d++) check_all(d, $sformatf("reset%0d", d), 1'b0, 8'd0, 2'b00, 1'b0, 1'b0);
        tb_RST = 1'b1;
        step(1);

        // One-shot, TB_DIV=10, ch1=10, ch0=2: TC[0] at +21, TC[1]+DONE at +101.
        do_start(D10, 16'h0A02, 1'b0);
        check_all(D10, "os10.start", 1'b0, 8'd0, 2'b00, 1'b1, 1'b0);
        for (int k = 1; k <= 102; k++) begin
            step(1);
            etc = (k == 21) ? 2'b01 : (k == 101) ? 2'b10 : 2'b00;
            check_all(D10, $sformatf("os10.k%0d", k), (k % 10 == 0) && (k <= 100),
                      (k >= 101) ? 8'd10 : 8'((k - 1) / 10), etc, k <= 100, k >= 101);
        end

        // Run clear, then a start with a zero terminal limit is ignored.
        rstq_s[D10] = 1'b1;
        step(1);
        rstq_s[D10] = 1'b0;
        check_all(D10, "rstq10", 1'b0, 8'd0, 2'b00, 1'b0, 1'b0);
        do_start(D10, 16'h0005, 1'b0);
        check_all(D10, "zero_lim", 1'b0, 8'd0, 2'b00, 1'b0, 1'b0);

        // Restart mid-run with new limits; timing measured from the new edge.
        do_start(D10, 16'h0403, 1'b0);
        step(15);
        check("restart.pre_q", 32'(q_s[D10]), 32'd1);
        do_start(D10, 16'h0501, 1'b0);
        check_all(D10, "restart.edge", 1'b0, 8'd0, 2'b00, 1'b1, 1'b0);
        step(10);
        check("restart.k10.tc", 32'(tc_s[D10]), 32'b00);
        step(1);
        check("restart.k11.tc", 32'(tc_s[D10]), 32'b01);
        check("restart.k11.q",  32'(q_s[D10]),  32'd1);
        step(40);
        check_all(D10, "restart.k51", 1'b0, 8'd5, 2'b10, 1'b0, 1'b1);

        // Periodic, TB_DIV=4, ch1=3, ch0=1.
        do_start(D4, 16'h0301, 1'b1);
        for (int k = 1; k <= 40; k++) begin
            step(1);
            c   = (k >= 5) ? (k - 5) / 4 + 1 : 0;
            etc = {(k >= 13) && ((k - 13) % 12 == 0), (k >= 5) && ((k - 5) % 12 == 0)};
            check_all(D4, $sformatf("per4.k%0d", k), k % 4 == 0, 8'(c % 3), etc, 1'b1, 1'b0);
        end

        // Restart over a pending tick, then pause 7 clocks: everything shifts by 7.
        do_start(D4, 16'h0301, 1'b1);
        check_all(D4, "pause.start", 1'b0, 8'd0, 2'b00, 1'b1, 1'b0);
        for (int k = 1; k <= 40; k++) begin
            pause_s[D4] = (k >= 2) && (k <= 8);
            step(1);
            c   = (k >= 12) ? (k - 12) / 4 + 1 : 0;
            etc = {(k >= 20) && ((k - 20) % 12 == 0), (k >= 12) && ((k - 12) % 12 == 0)};
            check_all(D4, $sformatf("pause.k%0d", k), (k >= 11) && ((k - 11) % 4 == 0),
                      8'(c % 3), etc, 1'b1, 1'b0);
        end
        pause_s[D4] = 1'b0;

        // Clear and start in the same clock: clear wins.
        start_s[D4] = 1'b1;
        rstq_s[D4]  = 1'b1;
        step(1);
        start_s[D4] = 1'b0;
        rstq_s[D4]  = 1'b0;
        check_all(D4, "rstq_start", 1'b0, 8'd0, 2'b00, 1'b0, 1'b0);
        step(5);
        check_all(D4, "rstq_start.later", 1'b0, 8'd0, 2'b00, 1'b0, 1'b0);

        // Reset while a tick is pending.
        do_start(D4, 16'h0301, 1'b0);
        step(4);
        check("rst_mid.tick_pending", 32'(tick_s[D4]), 32'd1);
        tb_RST = 1'b0;
        step(1);
        check_all(D4, "rst_mid", 1'b0, 8'd0, 2'b00, 1'b0, 1'b0);
        tb_RST = 1'b1;
        step(1);
        check_all(D4, "rst_mid.after", 1'b0, 8'd0, 2'b00, 1'b0, 1'b0);

        // TB_DIV=1: tick every RUN clock, ch0=2 at +3, ch1=5 with DONE at +6.
        do_start(D1, 16'h0502, 1'b0);
        check_all(D1, "div1.start", 1'b0, 8'd0, 2'b00, 1'b1, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            step(1);
            etc = (k == 3) ? 2'b01 : (k == 6) ? 2'b10 : 2'b00;
            check_all(D1, $sformatf("div1.k%0d", k), k <= 5, (k >= 6) ? 8'd5 : 8'(k - 1),
                      etc, k <= 5, k >= 6);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_bank.md
TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 Parameter TB_DIV, default 10: clocks per timebase tick, >=1; TB_DIV=1 makes every RUN clock a tick.
REQ-002 Parameter NCH, default 2: number of terminal-count channels, >=1.
REQ-003 Parameter QW, default 8: width of tick counter and of each channel limit.
REQ-004 CLK  in  1  sole clock, all logic on rising edge.
REQ-005 RST  in  1  reset, synchronous and active-low.
REQ-006 START  in  1  level sampled per clock; 1 = latch LIMITS/MODE and (re)start a run.
REQ-007 RST_Q  in  1  synchronous clear of run; returns to IDLE.
REQ-008 PAUSE  in  1  freezes timebase and tick counter while in RUN.
REQ-009 MODE  in  1  0 = one-shot, 1 = periodic; latched at START.
REQ-010 LIMITS  in  NCH*QW  channel i limit in bits [i*QW +: QW]; latched at START.
REQ-011 TICK  out  1  one-clock timebase tick pulse.
REQ-012 Q  out  QW  current tick count.
REQ-013 TC  out  NCH  per-channel one-clock terminal-count pulses.
REQ-014 BUSY  out  1  high in RUN; DONE  out  1  high in DONE state.

Function
REQ-015 States IDLE, RUN, DONE; all outputs registered.
REQ-016 Priority per clock: RST low > RST_Q > START > PAUSE > normal counting.
REQ-017 START in any state with latched terminal limit LIM[NCH-1] != 0: state<=RUN, Q<=0, timebase count TB_Q<=0, TICK<=0, TC<=0, LIMITS/MODE latched.
REQ-018 START with LIMITS channel NCH-1 field == 0: ignored, state unchanged.
REQ-019 RUN, PAUSE=0: TB_Q increments; at TB_Q==TB_DIV-1 TB_Q<=0 and TICK<=1 next cycle; otherwise TICK<=0.
REQ-020 RUN, PAUSE=1: TB_Q, Q, state hold; TICK<=0, TC<=0; no tick is lost or duplicated on release.
REQ-021 RUN, TICK==1, PAUSE=0: Q<=Q+1; TC[i]<=1 iff Q+1 == LIM[i]; else TC[i]<=0.
REQ-022 First TC for limit L visible L*TB_DIV+1 clocks after the START edge.
REQ-023 Limit 0 or limit > LIM[NCH-1] never fires; equal limits fire together.
REQ-024 At terminal (Q+1 == LIM[NCH-1] on tick): MODE=0 -> state<=DONE, Q holds at LIM[NCH-1]; MODE=1 -> Q<=0, stay RUN, TB_Q continues without gap.
REQ-025 DONE: Q, TB_Q held, TICK=0, TC=0 after the terminal pulse; leaves only via START or RST_Q.
REQ-026 IDLE: TB_Q=0, Q=0, TICK=0, TC=0.
REQ-027 RST_Q in any state: state<=IDLE, Q<=0, TB_Q<=0, TICK<=0, TC<=0.
REQ-028 START during RUN restarts from Q=0 with newly latched LIMITS; pending tick discarded.
REQ-029 Q arithmetic modulo 2^QW; wrap cannot occur since terminal limit bounds Q.

Reset
REQ-030 RST low at clock edge: state IDLE, Q=0, TB_Q=0, TICK=0, TC=0, BUSY=0, DONE=0, latched limits=0, latched MODE=0.
REQ-031 Reset mid-run discards run; no TC pulse in the cycle after reset.

Structure
REQ-032 Shared package holds state encoding (IDLE=0, RUN=1, DONE=2) and default parameter constants.
REQ-033 One sub-module tb_gen: TB_DIV timebase counter with enable/clear, TICK output.
REQ-034 Channel compare generated per channel; no per-channel counters.

Verification
REQ-035 TB_DIV=10, NCH=2, LIM={10,2}, MODE=0, START one clock -> TC[0] at +21, TC[1] and DONE at +101, Q=10 held.
REQ-036 MODE=1, LIM={3,1}, TB_DIV=4 -> TC[1] every 12 clocks from +13, TC[0] at +5,+17,+29; BUSY stays 1.
REQ-037 PAUSE high 7 clocks mid-run -> every subsequent TC/TICK delayed exactly 7 clocks.
REQ-038 RST_Q and START same clock in RUN -> IDLE, Q=0, no TC pulse.
REQ-039 START with LIM[NCH-1]=0 -> stays IDLE; START mid-run with new LIM -> Q=0, timing per REQ-022 from new edge.
REQ-040 RST low mid-run with TICK pending -> all outputs 0 next cycle; TB_DIV=1 run -> TICK every RUN clock.
